// File: rtl/fifo_out_arbiter_pkg.sv
// Flit-width constants shared with the router FIFOs, plus the pointer-width helper.
package fifo_out_arbiter_pkg;

  localparam int unsigned HDR_SZ     = 8;
  localparam int unsigned PL_SZ      = 16;
  localparam int unsigned ADDR_SZ    = 8;
  localparam int unsigned FLIT_W_DEF = HDR_SZ + PL_SZ + ADDR_SZ;
  localparam int unsigned CNT_W_DEF  = 16;

  // Bits needed to index n items; never below 1 so ports stay legal.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_out_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after base, with wrap.
module fifo_out_arbiter_rr_pick
  import fifo_out_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned PTR_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] base_i,
  output logic [NREQ-1:0]  gnt_onehot_o,
  output logic [PTR_W-1:0] gnt_idx_o,
  output logic             any_o
);

  localparam int unsigned IW = PTR_W + 1;

  // base + k never exceeds 2*NREQ-2, so one conditional subtract is an exact wrap.
  logic [IW-1:0] idx;

  always_comb begin
    gnt_onehot_o = '0;
    gnt_idx_o    = '0;
    any_o        = 1'b0;
    idx          = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = {1'b0, base_i} + IW'(k);
      if (idx >= IW'(NREQ)) begin
        idx = idx - IW'(NREQ);
      end
      if (!any_o && req_i[idx[PTR_W-1:0]]) begin
        any_o                           = 1'b1;
        gnt_idx_o                       = idx[PTR_W-1:0];
        gnt_onehot_o[idx[PTR_W-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_out_arbiter.sv
// Output-port scheduler: round-robin pop of route-matched input FIFOs into a
// one-entry output register feeding the downstream FIFO.
module fifo_out_arbiter
  import fifo_out_arbiter_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned FLIT_W = FLIT_W_DEF,
  parameter int unsigned PTR_W  = clog2(NREQ),
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        fifo_empty_i,
  input  logic [NREQ*FLIT_W-1:0] fifo_item_i,
  input  logic [NREQ-1:0]        route_match_i,
  output logic [NREQ-1:0]        fifo_read_o,
  input  logic                   out_full_i,
  output logic                   out_write_o,
  output logic [FLIT_W-1:0]      out_item_o,
  output logic [PTR_W-1:0]       grant_id_o,
  output logic [CNT_W-1:0]       flit_count_o
);

  logic [NREQ-1:0]   req, gnt_onehot;
  logic [PTR_W-1:0]  gnt_idx;
  logic              any_req;
  logic              can_load, xfer, pick;

  logic              out_valid_q, out_valid_d;
  logic [FLIT_W-1:0] out_item_q, out_item_d;
  logic [PTR_W-1:0]  grant_id_q, grant_id_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  flit_count_q, flit_count_d;

  assign req = ~fifo_empty_i & route_match_i;

  fifo_out_arbiter_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req_i        (req),
    .base_i       (rr_ptr_q),
    .gnt_onehot_o (gnt_onehot),
    .gnt_idx_o    (gnt_idx),
    .any_o        (any_req)
  );

  always_comb begin
    can_load     = !out_valid_q || !out_full_i;
    xfer         = out_valid_q && !out_full_i;
    pick         = can_load && any_req && !reset;
    fifo_read_o  = pick ? gnt_onehot : '0;

    out_valid_d  = out_valid_q;
    out_item_d   = out_item_q;
    grant_id_d   = grant_id_q;
    rr_ptr_d     = rr_ptr_q;
    flit_count_d = xfer ? flit_count_q + CNT_W'(1) : flit_count_q;

    if (pick) begin
      out_valid_d = 1'b1;
      grant_id_d  = gnt_idx;
      rr_ptr_d    = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      for (int i = 0; i < int'(NREQ); i++) begin
        if (gnt_onehot[i]) begin
          out_item_d = fifo_item_i[i*FLIT_W +: FLIT_W];
        end
      end
    end else if (xfer) begin
      // Drained with nothing to reload: item and grant id keep their last values.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_item_q   <= '0;
      grant_id_q   <= '0;
      rr_ptr_q     <= '0;
      flit_count_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_item_q   <= out_item_d;
      grant_id_q   <= grant_id_d;
      rr_ptr_q     <= rr_ptr_d;
      flit_count_q <= flit_count_d;
    end
  end

  assign out_write_o  = out_valid_q;
  assign out_item_o   = out_item_q;
  assign grant_id_o   = grant_id_q;
  assign flit_count_o = flit_count_q;

endmodule

// File: doc/fifo_out_arbiter.md
Name: fifo_out_arbiter

Overview:
- Output-port scheduler for a router. It shares one output link among NREQ input FIFOs, such as the per-port fifo instances in the router.
- It picks one non-empty, route-matched input FIFO per cycle in round-robin order and pops it through the FIFO's read strobe.
- The popped flit goes into a one-entry output register, which drives the downstream FIFO's write/full handshake.
- Sustains 1 flit/cycle when the downstream FIFO is not full.

Parameters:
- NREQ, 4, number of input FIFOs competing for this output; any value >= 2, not necessarily a power of two.
- FLIT_W, `HDR_SZ+`PL_SZ+`ADDR_SZ, flit width; must match the fifo item width.
- PTR_W, clog2(NREQ), width of the grant id and the round-robin pointer.
- CNT_W, 16, width of the forwarded-flit statistics counter.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- fifo_empty  input  NREQ  empty flag of each input FIFO.
- fifo_item  input  NREQ*FLIT_W  head item of each FIFO; requester i occupies bits [i*FLIT_W +: FLIT_W].
- route_match  input  NREQ  high when FIFO i's head flit is routed to this output.
- fifo_read  output  NREQ  pop strobe per FIFO; combinational; one-hot or zero.
- out_full  input  1  full flag of the downstream FIFO.
- out_write  output  1  write strobe to the downstream FIFO; equals out_valid.
- out_item  output  FLIT_W  flit held in the output register.
- grant_id  output  PTR_W  index of the requester that supplied out_item.
- flit_count  output  CNT_W  number of flits accepted downstream; wraps.

Behaviour:
- Request: req[i] = !fifo_empty[i] & route_match[i].
- Transfer: a downstream transfer occurs in a cycle when out_valid & !out_full.
- Load enable: can_load = !out_valid | !out_full. A register draining this cycle may be reloaded in the same cycle.
- Pick rule: when can_load and req != 0, the winner g is the first i with req[i] set, searching rr_ptr, rr_ptr+1, ... NREQ-1, 0, ... with explicit wrap (no power-of-two assumption).
- fifo_read[g] = 1 in that same cycle (combinational). All other bits are 0.
- fifo_read is 0 whenever can_load = 0, req = 0, or reset = 1. It never asserts toward an empty FIFO.
- On the next clk edge after a pick:
  - out_item <= fifo_item[g]
  - grant_id <= g
  - out_valid <= 1
  - rr_ptr <= (g == NREQ-1) ? 0 : g+1
- Latency: 1 cycle from FIFO head to out_item/out_write.
- Transfer without reload: if a transfer occurs and there is no new pick, out_valid <= 0. out_item and grant_id hold their last values.
- Blocked output: if out_valid & out_full, the register holds. No pick occurs, fifo_read = 0, and rr_ptr is unchanged.
- rr_ptr advances only on a pick. Idle cycles leave it unchanged.
- flit_count increments by 1 on each transfer and wraps from 2^CNT_W-1 to 0.
- Reset (any time, including mid-transfer):
  - out_valid = 0, out_write = 0, out_item = 0, grant_id = 0, rr_ptr = 0, flit_count = 0.
  - A held flit is discarded. The FIFOs are reset by the same signal.
- Fairness: with all NREQ requesting continuously and no backpressure, grants follow rr_ptr order. Each requester gets exactly one grant per NREQ cycles.
- A requester whose route_match drops while it is not yet granted is simply skipped. There is no lock and no stored request state.

Decomposition:
- Shared package/include (flit-width defines shared with fifo and router top): FLIT_W, clog2 function, CNT_W default.
- Sub-module rr_pick:
  - Combinational rotating-priority picker.
  - Inputs: req[NREQ], base[PTR_W].
  - Outputs: gnt_onehot[NREQ], gnt_idx[PTR_W], any.
- fifo_out_arbiter instantiates one rr_pick and owns the output register, rr_ptr and flit_count.

Test Plan:
1. Reset mid-operation: out_valid=1, then reset pulsed asynchronously between edges -> out_write=0, flit_count=0, fifo_read=0 immediately; after release the first grant goes to the lowest requesting index.
2. Single requester: NREQ=4, only FIFO 2 non-empty with route_match=1, 3 items A,B,C, out_full=0 -> fifo_read=4'b0100 for 3 consecutive cycles; out_item=A,B,C on the following 3 cycles with grant_id=2; flit_count=3.
3. Round-robin fairness: all 4 FIFOs non-empty and matched, out_full=0 for 8 cycles -> grant_id sequence 0,1,2,3,0,1,2,3; exactly one fifo_read bit high per cycle.
4. Backpressure: out_full=1 for 5 cycles while out_valid=1 -> fifo_read=0, out_item stable, rr_ptr unchanged, flit_count unchanged; first cycle after out_full=0, a new pick and a transfer happen in the same cycle.
5. Mask and wrap with NREQ=3: req only on 0 and 2, rr_ptr=2 -> grants 2,0,2,0; route_match[0]=0 with FIFO 0 non-empty -> FIFO 0 never read.
6. Counter wrap with CNT_W=4: 17 transfers -> flit_count = 1.
